// File: rtl/jc_phase_decoder.sv
// -----------------------------------------------------------------------------
// jc_phase_decoder
//
// Decodes the N-bit Johnson counter code from the upstream counter into a
// registered phase index and a one-hot phase strobe. Every accepted code is
// checked for legality and for a legal single-step advance (hold or +1 modulo
// 2N). Completed revolutions (phase 2N-1 -> 0) are counted.
//
// Handshake: there is no back-pressure. jc_in is accepted on every posedge
// with en=1; with en=0 all state holds and the pulse outputs are 0.
//
// Ports
//   clk           clock, all logic on posedge
//   rst           synchronous active-high reset, priority over en and err_clr
//   en            sample enable
//   jc_in         Johnson code, bit 0 is the LSB
//   err_clr       clears err_sticky (a same-cycle new error wins)
//   phase_idx     phase 0..2N-1 of the last legal sample
//   phase_onehot  bit phase_idx set while valid=1, all zero otherwise
//   valid         last accepted sample was legal
//   illegal       1-cycle pulse: accepted sample is not a Johnson code
//   step_err      1-cycle pulse: legal sample neither held nor advanced by 1
//   rev_tick      1-cycle pulse: phase wrapped 2N-1 -> 0
//   rev_cnt       revolutions since reset, wraps silently
//   err_sticky    set by illegal or step_err, held until err_clr
// -----------------------------------------------------------------------------
module jc_phase_decoder #(
   parameter int N     = 4,
   parameter int CNT_W = 8,
   localparam int IW   = $clog2(2 * N)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [N-1:0]     jc_in,
   input  logic             err_clr,
   output logic [IW-1:0]    phase_idx,
   output logic [2*N-1:0]   phase_onehot,
   output logic             valid,
   output logic             illegal,
   output logic             step_err,
   output logic             rev_tick,
   output logic [CNT_W-1:0] rev_cnt,
   output logic             err_sticky
);

   localparam logic [IW-1:0] LAST_PHASE = IW'(2 * N - 1);

   // primed: phase_idx holds a trusted previous phase, so step and wrap
   // checks are meaningful. Cleared by reset and by any illegal sample.
   logic primed;

   logic [N-1:0]    pat;
   logic            dec_legal;
   logic [IW-1:0]   dec_idx;
   logic [2*N-1:0]  dec_onehot;
   logic [IW-1:0]   next_idx;
   logic            is_step_err;
   logic            is_wrap;

   // Compare the input against every legal code. Phase k has k LSB ones for
   // k <= N, otherwise the top 2N-k bits set.
   always_comb begin
      pat        = '0;
      dec_legal  = 1'b0;
      dec_idx    = '0;
      dec_onehot = '0;
      for (int k = 0; k < 2 * N; k++) begin
         for (int b = 0; b < N; b++) begin
            pat[b] = (k <= N) ? (b < k) : (b >= k - N);
         end
         if (jc_in == pat) begin
            dec_legal     = 1'b1;
            dec_idx       = IW'(k);
            dec_onehot    = '0;
            dec_onehot[k] = 1'b1;
         end
      end
   end

   always_comb begin
      next_idx    = (phase_idx == LAST_PHASE) ? '0 : phase_idx + IW'(1);
      is_step_err = primed && (dec_idx != phase_idx) && (dec_idx != next_idx);
      is_wrap     = primed && (phase_idx == LAST_PHASE) && (dec_idx == '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         phase_idx    <= '0;
         phase_onehot <= '0;
         valid        <= 1'b0;
         illegal      <= 1'b0;
         step_err     <= 1'b0;
         rev_tick     <= 1'b0;
         rev_cnt      <= '0;
         err_sticky   <= 1'b0;
         primed       <= 1'b0;
      end else begin
         illegal  <= 1'b0;
         step_err <= 1'b0;
         rev_tick <= 1'b0;
         // Clear first; a new error below overrides it in the same cycle.
         if (err_clr) begin
            err_sticky <= 1'b0;
         end
         if (en) begin
            if (!dec_legal) begin
               illegal      <= 1'b1;
               valid        <= 1'b0;
               phase_onehot <= '0;
               primed       <= 1'b0;
               err_sticky   <= 1'b1;
            end else begin
               phase_idx    <= dec_idx;
               phase_onehot <= dec_onehot;
               valid        <= 1'b1;
               primed       <= 1'b1;
               if (is_step_err) begin
                  step_err   <= 1'b1;
                  err_sticky <= 1'b1;
               end
               if (is_wrap) begin
                  rev_tick <= 1'b1;
                  rev_cnt  <= rev_cnt + CNT_W'(1);
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_jc_phase_decoder.sv
// -----------------------------------------------------------------------------
// tb_jc_phase_decoder
//
// Directed bench for jc_phase_decoder. Two instances share all inputs: dut
// with the default 8-bit revolution counter and dut_w2 with a 2-bit counter
// so the counter wrap is reached in a few revolutions.
// -----------------------------------------------------------------------------
module tb_jc_phase_decoder;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic [3:0] jc_in;
   logic       err_clr;

   logic [2:0] phase_idx;
   logic [7:0] phase_onehot;
   logic       valid, illegal, step_err, rev_tick, err_sticky;
   logic [7:0] rev_cnt;

   logic [2:0] w2_phase_idx;
   logic [7:0] w2_phase_onehot;
   logic       w2_valid, w2_illegal, w2_step_err, w2_rev_tick, w2_err_sticky;
   logic [1:0] w2_rev_cnt;

   int n_cmp = 0;
   int n_err = 0;

   logic [3:0] jc_tab [8];

   always #5 clk = ~clk;

   jc_phase_decoder #(.N(4), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .en(en), .jc_in(jc_in), .err_clr(err_clr),
      .phase_idx(phase_idx), .phase_onehot(phase_onehot), .valid(valid),
      .illegal(illegal), .step_err(step_err), .rev_tick(rev_tick),
      .rev_cnt(rev_cnt), .err_sticky(err_sticky)
   );

   jc_phase_decoder #(.N(4), .CNT_W(2)) dut_w2 (
      .clk(clk), .rst(rst), .en(en), .jc_in(jc_in), .err_clr(err_clr),
      .phase_idx(w2_phase_idx), .phase_onehot(w2_phase_onehot), .valid(w2_valid),
      .illegal(w2_illegal), .step_err(w2_step_err), .rev_tick(w2_rev_tick),
      .rev_cnt(w2_rev_cnt), .err_sticky(w2_err_sticky)
   );

   // Drive one cycle of inputs, then sample 1 time unit after the posedge.
   task automatic drive(input logic r, input logic e, input logic [3:0] code, input logic clr);
      rst     = r;
      en      = e;
      jc_in   = code;
      err_clr = clr;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      drive(1'b1, 1'b0, 4'b0000, 1'b0);
      drive(1'b1, 1'b1, 4'b0011, 1'b1);
      n_cmp++;
      if ({phase_idx, phase_onehot, valid, illegal, step_err, rev_tick, rev_cnt, err_sticky} !== 24'h0) begin
         n_err++;
         $display("FAIL reset outputs got %h required 0",
                  {phase_idx, phase_onehot, valid, illegal, step_err, rev_tick, rev_cnt, err_sticky});
      end
      n_cmp++;
      if (w2_rev_cnt !== 2'd0) begin
         n_err++; $display("FAIL reset w2_rev_cnt got %0d required 0", w2_rev_cnt);
      end
   endtask

   task automatic test_revolution();
      logic [7:0] exp_oh;
      for (int i = 0; i < 9; i++) begin
         drive(1'b0, 1'b1, jc_tab[i % 8], 1'b0);
         exp_oh = 8'b1 << (i % 8);
         n_cmp++;
         if (phase_idx !== 3'(i % 8)) begin
            n_err++; $display("FAIL rev idx i=%0d got %0d required %0d", i, phase_idx, i % 8);
         end
         n_cmp++;
         if (phase_onehot !== exp_oh || valid !== 1'b1) begin
            n_err++; $display("FAIL rev onehot/valid i=%0d got %b/%b required %b/1", i, phase_onehot, valid, exp_oh);
         end
         n_cmp++;
         if (rev_tick !== (i == 8) || rev_cnt !== ((i == 8) ? 8'd1 : 8'd0)) begin
            n_err++; $display("FAIL rev tick/cnt i=%0d got %b/%0d required %b/%0d", i, rev_tick, rev_cnt, i == 8, (i == 8) ? 1 : 0);
         end
         n_cmp++;
         if ({illegal, step_err, err_sticky} !== 3'b000) begin
            n_err++; $display("FAIL rev errors i=%0d got %b required 000", i, {illegal, step_err, err_sticky});
         end
      end
   endtask

   task automatic test_illegal();
      // phase 0 held; 0101 is not a Johnson code
      drive(1'b0, 1'b1, 4'b0101, 1'b0);
      n_cmp++;
      if ({illegal, valid, phase_onehot, err_sticky, step_err} !== {1'b1, 1'b0, 8'h00, 1'b1, 1'b0}) begin
         n_err++; $display("FAIL illegal flags got ill=%b v=%b oh=%b st=%b se=%b required 1 0 00000000 1 0",
                           illegal, valid, phase_onehot, err_sticky, step_err);
      end
      n_cmp++;
      if (phase_idx !== 3'd0) begin
         n_err++; $display("FAIL illegal idx_hold got %0d required 0", phase_idx);
      end
      drive(1'b0, 1'b1, 4'b0011, 1'b0);
      n_cmp++;
      if ({phase_idx, valid, phase_onehot} !== {3'd2, 1'b1, 8'h04}) begin
         n_err++; $display("FAIL resync idx/valid/oh got %0d/%b/%b required 2/1/00000100", phase_idx, valid, phase_onehot);
      end
      n_cmp++;
      if ({illegal, step_err, err_sticky} !== 3'b001) begin
         n_err++; $display("FAIL resync flags got %b required 001", {illegal, step_err, err_sticky});
      end
   endtask

   task automatic test_step_err();
      drive(1'b0, 1'b1, 4'b1001, 1'b0);
      n_cmp++;
      if (illegal !== 1'b1) begin
         n_err++; $display("FAIL step 1001 illegal got %b required 1", illegal);
      end
      // resync at phase 1 with a clear: no step_err, sticky cleared
      drive(1'b0, 1'b1, 4'b0001, 1'b1);
      n_cmp++;
      if ({phase_idx, step_err, err_sticky, illegal} !== {3'd1, 3'b000}) begin
         n_err++; $display("FAIL step resync got idx=%0d se=%b st=%b ill=%b required 1 0 0 0", phase_idx, step_err, err_sticky, illegal);
      end
      drive(1'b0, 1'b1, 4'b0111, 1'b0);
      n_cmp++;
      if ({phase_idx, step_err, err_sticky, valid} !== {3'd3, 3'b111}) begin
         n_err++; $display("FAIL step skip got idx=%0d se=%b st=%b v=%b required 3 1 1 1", phase_idx, step_err, err_sticky, valid);
      end
      drive(1'b0, 1'b1, 4'b0111, 1'b0);
      n_cmp++;
      if ({phase_idx, step_err} !== {3'd3, 1'b0}) begin
         n_err++; $display("FAIL step hold got idx=%0d se=%b required 3 0", phase_idx, step_err);
      end
      drive(1'b0, 1'b1, 4'b1111, 1'b0);
      n_cmp++;
      if ({phase_idx, step_err} !== {3'd4, 1'b0}) begin
         n_err++; $display("FAIL step advance got idx=%0d se=%b required 4 0", phase_idx, step_err);
      end
      drive(1'b0, 1'b1, 4'b0011, 1'b0);
      n_cmp++;
      if ({phase_idx, step_err} !== {3'd2, 1'b1}) begin
         n_err++; $display("FAIL step backward got idx=%0d se=%b required 2 1", phase_idx, step_err);
      end
      drive(1'b0, 1'b1, 4'b0011, 1'b0);
      n_cmp++;
      if ({phase_idx, step_err, rev_tick} !== {3'd2, 2'b00}) begin
         n_err++; $display("FAIL step hold2 got idx=%0d se=%b rt=%b required 2 0 0", phase_idx, step_err, rev_tick);
      end
   endtask

   task automatic test_err_clr();
      // jump 2 -> 6 with clear in the same cycle: set wins
      drive(1'b0, 1'b1, 4'b1100, 1'b1);
      n_cmp++;
      if ({step_err, err_sticky} !== 2'b11) begin
         n_err++; $display("FAIL clr vs step got se=%b st=%b required 1 1", step_err, err_sticky);
      end
      drive(1'b0, 1'b1, 4'b1100, 1'b1);
      n_cmp++;
      if ({step_err, err_sticky} !== 2'b00) begin
         n_err++; $display("FAIL clr alone got se=%b st=%b required 0 0", step_err, err_sticky);
      end
      drive(1'b0, 1'b1, 4'b0101, 1'b1);
      n_cmp++;
      if ({illegal, err_sticky} !== 2'b11) begin
         n_err++; $display("FAIL clr vs illegal got ill=%b st=%b required 1 1", illegal, err_sticky);
      end
      drive(1'b0, 1'b1, 4'b1100, 1'b1);
      n_cmp++;
      if ({phase_idx, valid, err_sticky, step_err} !== {3'd6, 1'b1, 2'b00}) begin
         n_err++; $display("FAIL clr resync got idx=%0d v=%b st=%b se=%b required 6 1 0 0", phase_idx, valid, err_sticky, step_err);
      end
   endtask

   task automatic test_wrap_and_pause();
      int exp_cnt;
      int ticks;
      exp_cnt = 0;
      ticks   = 0;
      drive(1'b1, 1'b0, 4'b0000, 1'b0);
      for (int i = 0; i < 33; i++) begin
         drive(1'b0, 1'b1, jc_tab[i % 8], 1'b0);
         if (i > 0 && (i % 8) == 0) exp_cnt++;
         if (w2_rev_tick === 1'b1) ticks++;
         n_cmp++;
         if (phase_idx !== 3'(i % 8) || step_err !== 1'b0 || illegal !== 1'b0) begin
            n_err++; $display("FAIL wrap idx i=%0d got %0d se=%b ill=%b required %0d 0 0", i, phase_idx, step_err, illegal, i % 8);
         end
         n_cmp++;
         if (rev_tick !== (i > 0 && (i % 8) == 0)) begin
            n_err++; $display("FAIL wrap tick i=%0d got %b required %b", i, rev_tick, i > 0 && (i % 8) == 0);
         end
         n_cmp++;
         if (rev_cnt !== 8'(exp_cnt) || w2_rev_cnt !== 2'(exp_cnt)) begin
            n_err++; $display("FAIL wrap cnt i=%0d got %0d/%0d required %0d/%0d", i, rev_cnt, w2_rev_cnt, 8'(exp_cnt), 2'(exp_cnt));
         end
         if (i == 16) begin
            for (int j = 0; j < 3; j++) begin
               drive(1'b0, 1'b0, 4'b0101, 1'b0);
               n_cmp++;
               if ({phase_idx, phase_onehot, valid, illegal, step_err, rev_tick, err_sticky} !== {3'd0, 8'h01, 1'b1, 4'b0000}) begin
                  n_err++; $display("FAIL pause j=%0d got idx=%0d oh=%b v=%b ill=%b se=%b rt=%b st=%b required 0 00000001 1 0 0 0 0",
                                    j, phase_idx, phase_onehot, valid, illegal, step_err, rev_tick, err_sticky);
               end
               n_cmp++;
               if (rev_cnt !== 8'd2 || w2_rev_cnt !== 2'd2) begin
                  n_err++; $display("FAIL pause cnt j=%0d got %0d/%0d required 2/2", j, rev_cnt, w2_rev_cnt);
               end
            end
         end
      end
      n_cmp++;
      if (ticks !== 4) begin
         n_err++; $display("FAIL wrap tick count got %0d required 4", ticks);
      end
   endtask

   task automatic test_reset_mid();
      for (int k = 1; k < 6; k++) drive(1'b0, 1'b1, jc_tab[k], 1'b0);
      drive(1'b0, 1'b1, 4'b0101, 1'b0);
      drive(1'b0, 1'b1, 4'b1110, 1'b0);
      n_cmp++;
      if ({phase_idx, valid, err_sticky, rev_cnt} !== {3'd5, 2'b11, 8'd4}) begin
         n_err++; $display("FAIL mid pre got idx=%0d v=%b st=%b cnt=%0d required 5 1 1 4", phase_idx, valid, err_sticky, rev_cnt);
      end
      drive(1'b1, 1'b1, 4'b1100, 1'b1);
      n_cmp++;
      if ({phase_idx, phase_onehot, valid, illegal, step_err, rev_tick, rev_cnt, err_sticky} !== 24'h0) begin
         n_err++; $display("FAIL mid reset got %h required 0",
                           {phase_idx, phase_onehot, valid, illegal, step_err, rev_tick, rev_cnt, err_sticky});
      end
      drive(1'b0, 1'b1, 4'b0000, 1'b0);
      n_cmp++;
      if ({phase_idx, phase_onehot, valid, step_err, rev_tick, rev_cnt, err_sticky} !== {3'd0, 8'h01, 1'b1, 2'b00, 8'd0, 1'b0}) begin
         n_err++; $display("FAIL mid resume got idx=%0d oh=%b v=%b se=%b rt=%b cnt=%0d st=%b required 0 00000001 1 0 0 0 0",
                           phase_idx, phase_onehot, valid, step_err, rev_tick, rev_cnt, err_sticky);
      end
      drive(1'b0, 1'b1, 4'b0001, 1'b0);
      n_cmp++;
      if ({phase_idx, step_err} !== {3'd1, 1'b0}) begin
         n_err++; $display("FAIL mid advance got idx=%0d se=%b required 1 0", phase_idx, step_err);
      end
   endtask

   initial begin
      jc_tab[0] = 4'b0000; jc_tab[1] = 4'b0001; jc_tab[2] = 4'b0011; jc_tab[3] = 4'b0111;
      jc_tab[4] = 4'b1111; jc_tab[5] = 4'b1110; jc_tab[6] = 4'b1100; jc_tab[7] = 4'b1000;
      rst = 1'b1; en = 1'b0; jc_in = 4'b0000; err_clr = 1'b0;
      test_reset();
      test_revolution();
      test_illegal();
      test_step_err();
      test_err_clr();
      test_wrap_and_pause();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired at time %0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
